alu_seq: RTL and testbench
==========================

// Module: alu_seq
// PURPOSE
//   Parametrised, registered ALU for the ARMv7 datapath; successor to the single-cycle combinational ALU.
//   Keeps the 4-bit ALU_OP encoding and NZCV rules, widens to WIDTH bits and registers F/NZCV.
//   Adds a start/busy/done handshake and an optional multi-cycle shift-add multiplier (MUL, UMULH).
//   Sits between the operand/shifter stage and the register-file write-back / CPSR update.
// PARAMETERS
//   WIDTH  32  operand/result width in bits (>=8)
// PORTS
//   clk              in   1      single clock, rising edge
//   rst              in   1      asynchronous, active-high reset
//   start            in   1      request; sampled only when busy==0
//   ALU_OP           in   4      operation, sampled with start
//   A, B             in   WIDTH  operands, sampled with start
//   Shift_Carry_Out  in   1      shifter carry, sampled with start
//   CF, VF           in   1      current CPSR C/V, sampled with start
//   busy             out  1      1 while a multi-cycle op is in progress
//   done             out  1      one-cycle pulse: F/NZCV valid
//   F                out  WIDTH  registered result, held until next done
//   NZCV             out  4      registered flags {N,Z,C,V}, held until next done
// BEHAVIOUR
//   Reset: F=0, NZCV=4'b0000, busy=0, done=0, FSM=IDLE; asserting rst mid-op aborts at once, no done.
//   FSM: IDLE --start & MUL op--> MUL --WIDTH iterations--> IDLE. All other ops complete from IDLE.
//   start while busy==1: ignored, no effect on the running op. start in the done cycle: accepted.
//   Single-cycle ops: start sampled at edge k -> done=1, F/NZCV updated at edge k+1; busy stays 0.
//   Ops (W=WIDTH, C = carry out of a (W+1)-bit computation):
//     0000 A&B  0001 A^B  0010 A-B  0011 B-A  0100 A+B  0101 A+B+CF
//     0110 A-B+CF-1  0111 B-A+CF-1  1000 A  1010 A-B+4  1100 A|B
//     1101 B  1110 A&~B  1111 ~B  1001 MUL low  1011 UMULH (unsigned, high W bits)
//   Flags: N=F[W-1]; Z=(F==0).
//     Arithmetic 0010-0111: V=A[W-1]^B[W-1]^F[W-1]^C; C flag = C for 0100/0101, ~C for 0010/0011/0110/0111.
//     All other ops: C flag = Shift_Carry_Out, V flag = VF.
//   1010 is an address calc (flags = logical rule), with wrap-around modulo 2^W.
//   Multiply: unsigned shift-add; 2W-bit accumulator, one multiplier bit per clk.
//     busy=1 for exactly WIDTH cycles; done at edge k+WIDTH+1 after the start edge k.
//     Multiply flags: C flag = CF, V flag = VF (preserved).
//   F/NZCV change only on a done edge or on reset; done is never high two cycles in a row for one op.
// CONFIGURATION
//   ALU_MUL_EN defined: ops 1001/1011 run the multi-cycle multiplier described above.
//   ALU_MUL_EN undefined: no multiplier logic. 1001/1011 complete in one cycle with F=0, NZCV={0,1,Shift_Carry_Out,VF}.
//     busy is tied to 0.
// TESTING (WIDTH=32)
//   ADD 0x7FFFFFFF+0x00000001 -> done 1 cycle later; F=0x80000000, NZCV=4'b1001, busy stays 0.
//   SUB 5-5 -> F=0, NZCV=4'b0110. RSB (0011) A=1,B=0 -> F=0xFFFFFFFF, NZCV=4'b1000.
//   ADC 0xFFFFFFFF+0 with CF=1 -> F=0, NZCV=4'b0110. AND with Shift_Carry_Out=1, VF=1 -> C=1, V=1.
//   [ALU_MUL_EN] MUL 0x00010000*0x00010003 -> busy 32 cycles, done at cycle 33, F=0x00030000.
//     Then UMULH, same operands -> F=0x00000001. Also: start pulsed mid-op is ignored.
//   [ALU_MUL_EN] rst raised 10 cycles into MUL -> busy=0, done=0, F=0, NZCV=0 immediately.
//     Then ADD 2+3 -> F=5 one cycle later.
//   [no ALU_MUL_EN] op 1001, A=3, B=4, Shift_Carry_Out=0, VF=0 -> done 1 cycle later, F=0, NZCV=4'b0100, busy=0.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with a start/busy/done handshake.
// Operands and operation are captured on an accepted start. Single-cycle
// ops write F/NZCV on the following edge. Define ALU_MUL_EN to build the
// multi-cycle shift-add multiplier for ops 1001 (MUL low) and 1011 (UMULH).
// Without ALU_MUL_EN those two ops finish in one cycle with F=0.
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       ALU_OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Shift_Carry_Out,
    input  logic             CF,
    input  logic             VF,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] F,
    output logic [3:0]       NZCV
);

    localparam logic [3:0] OpAnd  = 4'b0000;
    localparam logic [3:0] OpEor  = 4'b0001;
    localparam logic [3:0] OpSub  = 4'b0010;
    localparam logic [3:0] OpRsb  = 4'b0011;
    localparam logic [3:0] OpAdd  = 4'b0100;
    localparam logic [3:0] OpAdc  = 4'b0101;
    localparam logic [3:0] OpSbc  = 4'b0110;
    localparam logic [3:0] OpRsc  = 4'b0111;
    localparam logic [3:0] OpMovA = 4'b1000;
    localparam logic [3:0] OpMul  = 4'b1001;
    localparam logic [3:0] OpAddr = 4'b1010;
    localparam logic [3:0] OpMulh = 4'b1011;
    localparam logic [3:0] OpOrr  = 4'b1100;
    localparam logic [3:0] OpMovB = 4'b1101;
    localparam logic [3:0] OpBic  = 4'b1110;
    localparam logic [3:0] OpMvn  = 4'b1111;

    // Captured request
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             sco_q;
    logic             cf_q;
    logic             vf_q;
    logic             pend_q;

    logic             accept;
    logic             is_mul_in;

    // Single-cycle datapath
    logic [WIDTH:0]   ext_a;
    logic [WIDTH:0]   ext_b;
    logic [WIDTH:0]   wide;
    logic             arith;
    logic             inv_c;
    logic [WIDTH-1:0] sc_f;
    logic [3:0]       sc_nzcv;

    // Write-back selection
    logic             wb_valid;
    logic [WIDTH-1:0] wb_f;
    logic [3:0]       wb_nzcv;

`ifdef ALU_MUL_EN
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [0:0] {
        StIdle,
        StMul
    } state_t;

    state_t            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              fin_q, fin_d;
    logic [WIDTH:0]    psum;
    logic [WIDTH-1:0]  mul_f;

    assign is_mul_in = (ALU_OP == OpMul) || (ALU_OP == OpMulh);
    assign busy      = (state_q == StMul);
`else
    assign is_mul_in = 1'b0;
    assign busy      = 1'b0;
`endif

    assign accept = start && !busy;

    // Capture operands on an accepted start; pend_q marks a single-cycle op in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= 4'b0000;
            a_q    <= '0;
            b_q    <= '0;
            sco_q  <= 1'b0;
            cf_q   <= 1'b0;
            vf_q   <= 1'b0;
            pend_q <= 1'b0;
        end else begin
            pend_q <= 1'b0;
            if (accept) begin
                op_q   <= ALU_OP;
                a_q    <= A;
                b_q    <= B;
                sco_q  <= Shift_Carry_Out;
                cf_q   <= CF;
                vf_q   <= VF;
                pend_q <= !is_mul_in;
            end
        end
    end

    // Single-cycle result and flags from the captured request.
    always_comb begin
        ext_a = {1'b0, a_q};
        ext_b = {1'b0, b_q};
        wide  = '0;
        arith = 1'b0;
        inv_c = 1'b0;
        case (op_q)
            OpAnd:  wide = {1'b0, a_q & b_q};
            OpEor:  wide = {1'b0, a_q ^ b_q};
            OpSub: begin
                wide  = ext_a - ext_b;
                arith = 1'b1;
                inv_c = 1'b1;
            end
            OpRsb: begin
                wide  = ext_b - ext_a;
                arith = 1'b1;
                inv_c = 1'b1;
            end
            OpAdd: begin
                wide  = ext_a + ext_b;
                arith = 1'b1;
            end
            OpAdc: begin
                wide  = ext_a + ext_b + {{WIDTH{1'b0}}, cf_q};
                arith = 1'b1;
            end
            // x - y + CF - 1 is x - y - !CF
            OpSbc: begin
                wide  = ext_a - ext_b - {{WIDTH{1'b0}}, ~cf_q};
                arith = 1'b1;
                inv_c = 1'b1;
            end
            OpRsc: begin
                wide  = ext_b - ext_a - {{WIDTH{1'b0}}, ~cf_q};
                arith = 1'b1;
                inv_c = 1'b1;
            end
            OpMovA: wide = {1'b0, a_q};
            // Address calculation wraps modulo 2^WIDTH; its carry is not used.
            OpAddr: wide = {1'b0, a_q - b_q + WIDTH'(4)};
            OpOrr:  wide = {1'b0, a_q | b_q};
            OpMovB: wide = {1'b0, b_q};
            OpBic:  wide = {1'b0, a_q & ~b_q};
            OpMvn:  wide = {1'b0, ~b_q};
            // Multiply ops reaching this path only happen without the multiplier: F=0.
            default: wide = '0;
        endcase

        sc_f       = wide[WIDTH-1:0];
        sc_nzcv[3] = sc_f[WIDTH-1];
        sc_nzcv[2] = (sc_f == '0);
        if (arith) begin
            sc_nzcv[1] = inv_c ? ~wide[WIDTH] : wide[WIDTH];
            sc_nzcv[0] = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sc_f[WIDTH-1] ^ wide[WIDTH];
        end else begin
            sc_nzcv[1] = sco_q;
            sc_nzcv[0] = vf_q;
        end
    end

`ifdef ALU_MUL_EN
    // Multiplier FSM and accumulator registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            fin_q   <= fin_d;
        end
    end

    // Shift-add: {hi,lo} starts as {0,B}; each step adds A into hi if lo[0] and shifts right.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        fin_d   = 1'b0;
        psum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_q} : '0);
        case (state_q)
            StIdle: begin
                if (accept && is_mul_in) begin
                    state_d = StMul;
                    cnt_d   = '0;
                    hi_d    = '0;
                    lo_d    = B;
                end
            end
            StMul: begin
                {hi_d, lo_d} = {psum, lo_q[WIDTH-1:1]};
                cnt_d        = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StIdle;
                    fin_d   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // op_q[1] distinguishes UMULH (1011) from MUL low (1001).
    assign mul_f = op_q[1] ? hi_q : lo_q;
`endif

    // Pick which finished operation, if any, writes back this edge.
    always_comb begin
        wb_valid = pend_q;
        wb_f     = sc_f;
        wb_nzcv  = sc_nzcv;
`ifdef ALU_MUL_EN
        // A finishing multiply never coincides with a pending single-cycle op.
        if (fin_q) begin
            wb_valid = 1'b1;
            wb_f     = mul_f;
            wb_nzcv  = {mul_f[WIDTH-1], (mul_f == '0), cf_q, vf_q};
        end
`endif
    end

    // Result/flag registers change only on a done edge or reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            F    <= '0;
            NZCV <= 4'b0000;
            done <= 1'b0;
        end else begin
            done <= wb_valid;
            if (wb_valid) begin
                F    <= wb_f;
                NZCV <= wb_nzcv;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed, table-driven bench for alu_seq at WIDTH=32.
// Multiply sequences are built only when ALU_MUL_EN is defined.
module tb_alu_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  ALU_OP;
    logic [31:0] A;
    logic [31:0] B;
    logic        Shift_Carry_Out;
    logic        CF;
    logic        VF;
    logic        busy;
    logic        done;
    logic [31:0] F;
    logic [3:0]  NZCV;

    int checks;
    int errors;

    alu_seq #(.WIDTH(32)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .ALU_OP(ALU_OP),
        .A(A),
        .B(B),
        .Shift_Carry_Out(Shift_Carry_Out),
        .CF(CF),
        .VF(VF),
        .busy(busy),
        .done(done),
        .F(F),
        .NZCV(NZCV)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        sco;
        logic        cf;
        logic        vf;
        logic [31:0] f;
        logic [3:0]  nzcv;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs[NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic sco, input logic cf, input logic vf);
        ALU_OP          = op;
        A               = a;
        B               = b;
        Shift_Carry_Out = sco;
        CF              = cf;
        VF              = vf;
    endtask

    // Issue one single-cycle op and check the result one cycle after the start edge.
    task automatic run_single(input string name, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic sco, input logic cf,
                              input logic vf, input logic [31:0] ef, input logic [3:0] en);
        @(negedge clk);
        drive(op, a, b, sco, cf, vf);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({name, " busy0"}, {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk({name, " done"}, {31'b0, done}, 32'd1);
        chk({name, " busy"}, {31'b0, busy}, 32'd0);
        chk({name, " F"}, F, ef);
        chk({name, " NZCV"}, {28'b0, NZCV}, {28'b0, en});
        @(posedge clk);
        #1;
        chk({name, " done_pulse"}, {31'b0, done}, 32'd0);
        chk({name, " F_held"}, F, ef);
    endtask

`ifdef ALU_MUL_EN
    // Issue a multiply; optionally pulse a conflicting start mid-operation.
    task automatic run_mul(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic cf, input logic vf,
                           input logic [31:0] ef, input logic [3:0] en, input logic poke);
        int n;
        int bcnt;
        @(negedge clk);
        drive(op, a, b, 1'b0, cf, vf);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        bcnt  = busy ? 1 : 0;
        n     = 0;
        while (n < 100) begin
            @(posedge clk);
            #1;
            n++;
            if (poke && n == 5) begin
                drive(4'b0100, 32'd99, 32'd1, 1'b1, ~cf, ~vf);
                start = 1'b1;
            end
            if (poke && n == 6) start = 1'b0;
            if (busy) bcnt++;
            if (done) break;
        end
        chk({name, " done_cycle"}, n, 33);
        chk({name, " busy_cycles"}, bcnt, 32);
        chk({name, " F"}, F, ef);
        chk({name, " NZCV"}, {28'b0, NZCV}, {28'b0, en});
        @(posedge clk);
        #1;
        chk({name, " done_pulse"}, {31'b0, done}, 32'd0);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;

        //            op       A             B             sco   cf    vf    F             NZCV
        vecs[0]  = '{4'b0100, 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 32'h80000000, 4'b1001};
        vecs[1]  = '{4'b0010, 32'd5,        32'd5,        1'b0, 1'b0, 1'b0, 32'h00000000, 4'b0110};
        vecs[2]  = '{4'b0011, 32'd1,        32'd0,        1'b0, 1'b0, 1'b0, 32'hFFFFFFFF, 4'b1000};
        vecs[3]  = '{4'b0101, 32'hFFFFFFFF, 32'd0,        1'b0, 1'b1, 1'b0, 32'h00000000, 4'b0110};
        vecs[4]  = '{4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 1'b1, 1'b0, 1'b1, 32'hF000F000, 4'b1011};
        vecs[5]  = '{4'b0001, 32'hFFFF0000, 32'h0F0F0F0F, 1'b0, 1'b0, 1'b0, 32'hF0F00F0F, 4'b1000};
        vecs[6]  = '{4'b0110, 32'd10,       32'd3,        1'b0, 1'b0, 1'b0, 32'd6,        4'b0010};
        vecs[7]  = '{4'b0111, 32'd10,       32'd3,        1'b0, 1'b1, 1'b0, 32'hFFFFFFF9, 4'b1000};
        vecs[8]  = '{4'b1000, 32'd0,        32'd123,      1'b1, 1'b0, 1'b0, 32'h00000000, 4'b0110};
        vecs[9]  = '{4'b1010, 32'hFFFFFFFE, 32'd1,        1'b0, 1'b0, 1'b1, 32'h00000001, 4'b0001};
        vecs[10] = '{4'b1100, 32'h00000F00, 32'h000000F0, 1'b1, 1'b0, 1'b0, 32'h00000FF0, 4'b0010};
        vecs[11] = '{4'b1101, 32'h12345678, 32'h80000000, 1'b0, 1'b0, 1'b0, 32'h80000000, 4'b1000};
        vecs[12] = '{4'b1110, 32'hFFFFFFFF, 32'h0000FFFF, 1'b0, 1'b0, 1'b0, 32'hFFFF0000, 4'b1000};
        vecs[13] = '{4'b1111, 32'h00000000, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'h00000000, 4'b0111};
        vecs[14] = '{4'b0010, 32'h80000000, 32'd1,        1'b0, 1'b0, 1'b0, 32'h7FFFFFFF, 4'b0011};
        vecs[15] = '{4'b0100, 32'hFFFFFFFF, 32'd2,        1'b0, 1'b0, 1'b1, 32'h00000001, 4'b0010};

        rst   = 1'b1;
        start = 1'b0;
        drive(4'b0000, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset F", F, 32'd0);
        chk("reset NZCV", {28'b0, NZCV}, 32'd0);
        chk("reset busy", {31'b0, busy}, 32'd0);
        chk("reset done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            run_single($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sco,
                       vecs[i].cf, vecs[i].vf, vecs[i].f, vecs[i].nzcv);
        end

        // Back-to-back: a start during the done cycle is accepted.
        @(negedge clk);
        drive(4'b0100, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0);
        start = 1'b1;
        @(posedge clk);
        #1;
        drive(4'b0010, 32'd9, 32'd2, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b first done", {31'b0, done}, 32'd1);
        chk("b2b first F", F, 32'd5);
        @(posedge clk);
        #1;
        chk("b2b second done", {31'b0, done}, 32'd1);
        chk("b2b second F", F, 32'd7);
        chk("b2b second NZCV", {28'b0, NZCV}, {28'b0, 4'b0010});
        @(posedge clk);
        #1;
        chk("b2b done_pulse", {31'b0, done}, 32'd0);

`ifdef ALU_MUL_EN
        run_mul("mul", 4'b1001, 32'h00010000, 32'h00010003, 1'b1, 1'b0,
                32'h00030000, 4'b0010, 1'b0);
        run_mul("umulh", 4'b1011, 32'h00010000, 32'h00010003, 1'b0, 1'b1,
                32'h00000001, 4'b0001, 1'b1);

        // Reset during a multiply aborts it immediately.
        @(negedge clk);
        drive(4'b1001, 32'h00010000, 32'h00010003, 1'b0, 1'b1, 1'b1);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("midop busy before rst", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        chk("midop rst busy", {31'b0, busy}, 32'd0);
        chk("midop rst done", {31'b0, done}, 32'd0);
        chk("midop rst F", F, 32'd0);
        chk("midop rst NZCV", {28'b0, NZCV}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_single("post-rst add", 4'b0100, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 32'd5, 4'b0000);
`else
        run_single("nomul 1001", 4'b1001, 32'd3, 32'd4, 1'b0, 1'b0, 1'b0, 32'd0, 4'b0100);
        run_single("nomul 1011", 4'b1011, 32'd3, 32'd4, 1'b1, 1'b0, 1'b1, 32'd0, 4'b0111);

        // Reset clears registered results.
        run_single("pre-rst add", 4'b0100, 32'd2, 32'd3, 1'b0, 1'b0, 1'b0, 32'd5, 4'b0000);
        #1;
        rst = 1'b1;
        #1;
        chk("rst F", F, 32'd0);
        chk("rst done", {31'b0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_single("post-rst eor", 4'b0001, 32'hFFFFFFFF, 32'd1, 1'b1, 1'b0, 1'b0,
                   32'hFFFFFFFE, 4'b1010);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
